alu_exec_unit: RTL

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_comb.sv | 45 ++++
 rtl/alu_exec_unit.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared ALU definitions. Holds the ALU control codes used by
//                the ALU control decoder and the execution unit, the FSM state
//                encoding of the execution unit, and a shift-op classifier.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

    // ALU control codes (4 bits)
    localparam logic [3:0] c_ALU_ADD  = 4'b0000;
    localparam logic [3:0] c_ALU_SUB  = 4'b0001;
    localparam logic [3:0] c_ALU_AND  = 4'b0010;
    localparam logic [3:0] c_ALU_OR   = 4'b0011;
    localparam logic [3:0] c_ALU_SLL  = 4'b0100;
    localparam logic [3:0] c_ALU_SLT  = 4'b0101;
    localparam logic [3:0] c_ALU_XOR  = 4'b0110;
    localparam logic [3:0] c_ALU_SRL  = 4'b0111;
    localparam logic [3:0] c_ALU_SLTU = 4'b1000;
    localparam logic [3:0] c_ALU_SRA  = 4'b1111;

    // Execution unit FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } exec_state_t;

    // Shifts run iteratively in the execution unit, everything else is
    // produced in one cycle by alu_comb.
    function automatic logic is_shift(input logic [3:0] ctrl);
        return (ctrl == c_ALU_SLL) || (ctrl == c_ALU_SRL) || (ctrl == c_ALU_SRA);
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_comb.sv
`default_nettype none
// ============================================================================
//  Module      : alu_comb
//  Description : Single-cycle ALU operations (add, sub, and, or, xor, slt,
//                sltu). Shift codes pass operand a through unchanged since
//                the shift itself is done serially by the execution unit.
//                Undefined codes give y = 0 with illegal = 1.
//  Ports       : alu_ctrl - operation code
//                a, b     - operands
//                y        - result
//                illegal  - alu_ctrl is not a defined code
//  Revision    : 1.0  initial release
// ============================================================================
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             illegal
);

    always_comb begin
        y       = '0;
        illegal = 1'b0;
        case (alu_ctrl)
            c_ALU_ADD:  y = a + b;
            c_ALU_SUB:  y = a - b;
            c_ALU_AND:  y = a & b;
            c_ALU_OR:   y = a | b;
            c_ALU_XOR:  y = a ^ b;
            c_ALU_SLT:  y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            c_ALU_SLTU: y = {{(WIDTH-1){1'b0}}, (a < b)};
            c_ALU_SLL,
            c_ALU_SRL,
            c_ALU_SRA:  y = a;
            default:    illegal = 1'b1;
        endcase
    end

endmodule : alu_comb
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module      : alu_exec_unit
//  Description : ALU execution unit with valid/ready handshakes. Single-cycle
//                ops complete one cycle after accept; shifts are done one bit
//                per cycle (latency 1 + shamt). Result, zero and illegal are
//                registered and held in DONE until consumed.
//  Ports       : clk, reset          - clock, synchronous active-high reset
//                in_valid / in_ready - request handshake
//                alu_ctrl, src_a, src_b - operation and operands
//                out_valid / out_ready  - result handshake
//                result, zero, illegal  - registered outputs
//  Revision    : 1.0  initial release
// ============================================================================
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    localparam logic [SHAMT_W-1:0] c_CNT_ONE = {{(SHAMT_W-1){1'b0}}, 1'b1};

    exec_state_t        r_state;
    exec_state_t        w_state_next;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   w_result_next;
    logic               r_zero;
    logic               w_zero_next;
    logic               r_illegal;
    logic               w_illegal_next;
    logic [SHAMT_W-1:0] r_cnt;
    logic [SHAMT_W-1:0] w_cnt_next;
    logic [3:0]         r_op;
    logic [3:0]         w_op_next;

    logic [WIDTH-1:0]   w_comb_y;
    logic               w_comb_illegal;

    alu_comb #(
        .WIDTH (WIDTH)
    ) u_alu_comb (
        .alu_ctrl (alu_ctrl),
        .a        (src_a),
        .b        (src_b),
        .y        (w_comb_y),
        .illegal  (w_comb_illegal)
    );

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
            r_cnt     <= '0;
            r_op      <= c_ALU_ADD;
        end else begin
            r_state   <= w_state_next;
            r_result  <= w_result_next;
            r_zero    <= w_zero_next;
            r_illegal <= w_illegal_next;
            r_cnt     <= w_cnt_next;
            r_op      <= w_op_next;
        end
    end

    // Next-state and datapath update
    always_comb begin
        w_state_next   = r_state;
        w_result_next  = r_result;
        w_zero_next    = r_zero;
        w_illegal_next = r_illegal;
        w_cnt_next     = r_cnt;
        w_op_next      = r_op;

        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_op_next      = alu_ctrl;
                    w_illegal_next = w_comb_illegal;
                    if (is_shift(alu_ctrl)) begin
                        w_result_next = src_a;
                        w_cnt_next    = src_b[SHAMT_W-1:0];
                        w_state_next  = (src_b[SHAMT_W-1:0] == '0) ? ST_DONE : ST_SHIFT;
                    end else begin
                        w_result_next = w_comb_y;
                        w_cnt_next    = '0;
                        w_state_next  = ST_DONE;
                    end
                    w_zero_next = (w_result_next == '0);
                end
            end

            ST_SHIFT: begin
                case (r_op)
                    c_ALU_SLL: w_result_next = {r_result[WIDTH-2:0], 1'b0};
                    c_ALU_SRA: w_result_next = {r_result[WIDTH-1], r_result[WIDTH-1:1]};
                    default:   w_result_next = {1'b0, r_result[WIDTH-1:1]};
                endcase
                w_zero_next = (w_result_next == '0);
                w_cnt_next  = r_cnt - c_CNT_ONE;
                // The counter reaches zero on this edge: this was the last bit.
                if (r_cnt == c_CNT_ONE) begin
                    w_state_next = ST_DONE;
                end
            end

            ST_DONE: begin
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign result    = r_result;
    assign zero      = r_zero;
    assign illegal   = r_illegal;

endmodule : alu_exec_unit
`default_nettype wire
